// File: rtl/wb_result_if.sv
// Bundle of M-stage inputs, data-memory response and registered writeback
// outputs shared by the writeback result stage and its driver.
interface wb_result_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            valid_M;
  logic [1:0]      ResultSrc_M;
  logic [XLEN-1:0] ALUResult_M;
  logic [XLEN-1:0] PCPlus4_M;
  logic [XLEN-1:0] ImmExt_M;
  logic [2:0]      Funct3_M;
  logic            RegWrite_M;
  logic [RD_W-1:0] Rd_M;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            flush_W;
  logic            stall_M;
  logic            valid_W;
  logic            RegWrite_W;
  logic [RD_W-1:0] Rd_W;
  logic [XLEN-1:0] Result_W;
  logic            misalign_W;
  logic            timeout_W;

  modport master (
    output valid_M, ResultSrc_M, ALUResult_M, PCPlus4_M, ImmExt_M, Funct3_M,
           RegWrite_M, Rd_M, mem_rvalid, mem_rdata, flush_W,
    input  stall_M, valid_W, RegWrite_W, Rd_W, Result_W, misalign_W, timeout_W
  );

  modport slave (
    input  valid_M, ResultSrc_M, ALUResult_M, PCPlus4_M, ImmExt_M, Funct3_M,
           RegWrite_M, Rd_M, mem_rvalid, mem_rdata, flush_W,
    output stall_M, valid_W, RegWrite_W, Rd_W, Result_W, misalign_W, timeout_W
  );
endinterface

// File: rtl/wb_result_stage.sv
// Writeback result stage: selects the M-stage result, extracts load data,
// waits for late memory beats with a timeout and registers the writeback.
module wb_result_stage #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  wb_result_if.slave  bus
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0]  rdata,
    input logic [OFF_W-1:0] off,
    input logic [2:0]       f3
  );
    logic [XLEN-1:0]    s;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    s  = rdata >> {off, 3'b000};
    sb = s[7:0];
    sh = s[15:0];
    sw = s[31:0];
    case (f3)
      3'b000:  load_extract = XLEN'(sb);
      3'b100:  load_extract = XLEN'(s[7:0]);
      3'b001:  load_extract = XLEN'(sh);
      3'b101:  load_extract = XLEN'(s[15:0]);
      3'b010:  load_extract = XLEN'(sw);
      3'b110:  load_extract = XLEN'(s[31:0]);
      default: load_extract = s;
    endcase
  endfunction

  // Misaligned also covers funct3 codes that do not exist at this XLEN.
  function automatic logic load_misaligned(
    input logic [OFF_W-1:0] off,
    input logic [2:0]       f3
  );
    case (f3)
      3'b000, 3'b100: load_misaligned = 1'b0;
      3'b001, 3'b101: load_misaligned = off[0];
      3'b010:         load_misaligned = (off[1:0] != 2'b00);
      3'b110:         load_misaligned = (XLEN != 64) || (off[1:0] != 2'b00);
      3'b011:         load_misaligned = (XLEN != 64) || (off != '0);
      default:        load_misaligned = 1'b1;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic [7:0]      wait_cnt, cnt_nxt;
  logic            stall;

  logic            done_vld, done_we, done_mis, done_to;
  logic [XLEN-1:0] done_res;

  logic            vld_p1, regwrite_p1, misalign_p1, timeout_p1;
  logic [RD_W-1:0] rd_p1;
  logic [XLEN-1:0] result_p1;

  logic            is_load, mis, we_ok;
  logic [XLEN-1:0] sel_res, ld_res;

  always_comb begin
    is_load = bus.valid_M && (bus.ResultSrc_M == 2'b01);
    mis     = load_misaligned(bus.ALUResult_M[OFF_W-1:0], bus.Funct3_M);
    ld_res  = load_extract(bus.mem_rdata, bus.ALUResult_M[OFF_W-1:0], bus.Funct3_M);
    we_ok   = bus.valid_M && bus.RegWrite_M && (bus.Rd_M != '0);
    case (bus.ResultSrc_M)
      2'b00:   sel_res = bus.ALUResult_M;
      2'b10:   sel_res = bus.PCPlus4_M;
      2'b11:   sel_res = bus.ImmExt_M;
      default: sel_res = ld_res;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    stall     = 1'b0;
    done_vld  = 1'b0;
    done_we   = 1'b0;
    done_mis  = 1'b0;
    done_to   = 1'b0;
    done_res  = result_p1;
    case (state)
      IDLE: begin
        if (bus.valid_M) begin
          if (!is_load) begin
            done_vld = !bus.flush_W;
            done_we  = we_ok && !bus.flush_W;
            done_res = sel_res;
          end else if (mis) begin
            done_vld = !bus.flush_W;
            done_mis = !bus.flush_W;
            done_res = bus.ALUResult_M;
          end else if (bus.mem_rvalid) begin
            done_vld = !bus.flush_W;
            done_we  = we_ok && !bus.flush_W;
            done_res = ld_res;
          end else begin
            stall     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A flush abandons the load; an outstanding beat must still be absorbed.
        if (bus.flush_W) begin
          state_nxt = bus.mem_rvalid ? IDLE : DRAIN;
        end else if (bus.mem_rvalid) begin
          done_vld  = 1'b1;
          done_we   = we_ok;
          done_res  = ld_res;
          state_nxt = IDLE;
        end else if (wait_cnt == TO_LAST) begin
          done_vld  = 1'b1;
          done_to   = 1'b1;
          done_res  = bus.ALUResult_M;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = wait_cnt + 8'd1;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (bus.mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered writeback ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      misalign_p1 <= 1'b0;
      timeout_p1  <= 1'b0;
      rd_p1       <= '0;
      result_p1   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= cnt_nxt;
      vld_p1      <= done_vld;
      regwrite_p1 <= done_we;
      misalign_p1 <= done_mis;
      timeout_p1  <= done_to;
      if (done_vld) begin
        result_p1 <= done_res;
        rd_p1     <= bus.Rd_M;
      end
    end
  end

  assign bus.stall_M    = stall && !rst;
  assign bus.valid_W    = vld_p1;
  assign bus.RegWrite_W = regwrite_p1;
  assign bus.Rd_W       = rd_p1;
  assign bus.Result_W   = result_p1;
  assign bus.misalign_W = misalign_p1;
  assign bus.timeout_W  = timeout_p1;

endmodule
